alpha_beta_predictor: RTL and testbench

Fixed-point alpha-beta tracking filter that consumes the three-phase trigger sequence (latch, update, predict) produced by the predictor trigger controller. It captures one measurement per frame, corrects its position/velocity state with the residual, and advances the prediction one frame. It enforces the latch→update→predict order and flags any violation. Gains are powers of two, so the datapath is add/shift/saturate only.

---
 rtl/alpha_beta_predictor.sv | 154 +++++++++++++++
 tb/tb_alpha_beta_predictor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alpha_beta_predictor.sv
// Fixed-point alpha-beta tracking filter driven by a latch/update/predict trigger sequence.
// Power-of-two gains keep the datapath to add, arithmetic shift and saturate.
module alpha_beta_predictor #(
   parameter int WIDTH       = 16,
   parameter int ALPHA_SHIFT = 1,
   parameter int BETA_SHIFT  = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             latch_trigger,
   input  logic             update_trigger,
   input  logic             predict_trigger,
   input  logic [WIDTH-1:0] measurement,
   output logic [WIDTH-1:0] position,
   output logic [WIDTH-1:0] velocity,
   output logic [WIDTH-1:0] residual,
   output logic             estimate_valid,
   output logic             seq_error
);

   typedef enum logic [1:0] {
      WAIT_LATCH   = 2'd0,
      WAIT_UPDATE  = 2'd1,
      WAIT_PREDICT = 2'd2
   } state_t;

   localparam logic signed [WIDTH+1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH+1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH+1:0] v);
      logic signed [WIDTH+1:0] c;
      if (v > SAT_MAX)      c = SAT_MAX;
      else if (v < SAT_MIN) c = SAT_MIN;
      else                  c = v;
      return c[WIDTH-1:0];
   endfunction

   state_t                   state_q, state_d;
   logic                     primed_q, primed_d;
   logic signed [WIDTH-1:0]  meas_q, meas_d;
   logic signed [WIDTH-1:0]  x_est_q, x_est_d;
   logic signed [WIDTH-1:0]  pos_q, pos_d;
   logic signed [WIDTH-1:0]  vel_q, vel_d;
   logic signed [WIDTH-1:0]  res_q, res_d;
   logic                     valid_q, valid_d;
   logic                     err_q, err_d;

   logic signed [WIDTH:0]    r_wide;
   logic signed [WIDTH+1:0]  r_ext, r_alpha, r_beta;
   logic signed [WIDTH+1:0]  pos_ext, vel_ext, x_ext;
   logic signed [WIDTH+1:0]  x_sum, v_sum, p_sum;
   logic                     multi_trig;

   always_comb begin
      state_d  = state_q;
      primed_d = primed_q;
      meas_d   = meas_q;
      x_est_d  = x_est_q;
      pos_d    = pos_q;
      vel_d    = vel_q;
      res_d    = res_q;
      valid_d  = 1'b0;
      err_d    = err_q;

      // Residual is exact at WIDTH+1 bits; the shifted terms are kept in
      // separate signed variables so the shifts stay arithmetic.
      r_wide  = {meas_q[WIDTH-1], meas_q} - {pos_q[WIDTH-1], pos_q};
      r_ext   = {r_wide[WIDTH], r_wide};
      r_alpha = r_ext >>> ALPHA_SHIFT;
      r_beta  = r_ext >>> BETA_SHIFT;
      pos_ext = {{2{pos_q[WIDTH-1]}}, pos_q};
      vel_ext = {{2{vel_q[WIDTH-1]}}, vel_q};
      x_ext   = {{2{x_est_q[WIDTH-1]}}, x_est_q};
      x_sum   = pos_ext + r_alpha;
      v_sum   = vel_ext + r_beta;
      p_sum   = x_ext + vel_ext;

      multi_trig = (latch_trigger & update_trigger) | (latch_trigger & predict_trigger) |
                   (update_trigger & predict_trigger);

      if (multi_trig) begin
         err_d = 1'b1;
      end else begin
         unique case (state_q)
            WAIT_LATCH: begin
               if (update_trigger || predict_trigger) begin
                  err_d = 1'b1;
               end else if (latch_trigger) begin
                  meas_d  = measurement;
                  state_d = WAIT_UPDATE;
               end
            end
            WAIT_UPDATE: begin
               if (latch_trigger || predict_trigger) begin
                  err_d = 1'b1;
               end else if (update_trigger) begin
                  if (!primed_q) begin
                     x_est_d  = meas_q;
                     vel_d    = '0;
                     res_d    = '0;
                     primed_d = 1'b1;
                  end else begin
                     x_est_d = sat(x_sum);
                     vel_d   = sat(v_sum);
                     res_d   = sat(r_ext);
                  end
                  state_d = WAIT_PREDICT;
               end
            end
            WAIT_PREDICT: begin
               if (latch_trigger || update_trigger) begin
                  err_d = 1'b1;
               end else if (predict_trigger) begin
                  pos_d   = sat(p_sum);
                  valid_d = 1'b1;
                  state_d = WAIT_LATCH;
               end
            end
            default: state_d = WAIT_LATCH;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= WAIT_LATCH;
         primed_q <= 1'b0;
         meas_q   <= '0;
         x_est_q  <= '0;
         pos_q    <= '0;
         vel_q    <= '0;
         res_q    <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         primed_q <= primed_d;
         meas_q   <= meas_d;
         x_est_q  <= x_est_d;
         pos_q    <= pos_d;
         vel_q    <= vel_d;
         res_q    <= res_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign position       = pos_q;
   assign velocity       = vel_q;
   assign residual       = res_q;
   assign estimate_valid = valid_q;
   assign seq_error      = err_q;

endmodule

// File: tb/tb_alpha_beta_predictor.sv
// Directed bench for alpha_beta_predictor: priming, tracking, protocol faults,
// saturation and asynchronous reset, with hand-computed expectations.
module tb_alpha_beta_predictor;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        latch_trigger = 1'b0;
   logic        update_trigger = 1'b0;
   logic        predict_trigger = 1'b0;
   logic [15:0] measurement = '0;
   logic [15:0] position, velocity, residual;
   logic        estimate_valid, seq_error;

   int errors = 0;
   int checks = 0;

   alpha_beta_predictor #(.WIDTH(16), .ALPHA_SHIFT(1), .BETA_SHIFT(3)) dut (
      .clock          (clock),
      .reset          (reset),
      .latch_trigger  (latch_trigger),
      .update_trigger (update_trigger),
      .predict_trigger(predict_trigger),
      .measurement    (measurement),
      .position       (position),
      .velocity       (velocity),
      .residual       (residual),
      .estimate_valid (estimate_valid),
      .seq_error      (seq_error)
   );

   always #5 clock = ~clock;

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      step();
   endtask

   // Drives latch, update, predict on consecutive cycles; returns just after
   // the edge that sampled predict (the estimate_valid cycle).
   task automatic frame(input logic [15:0] m);
      latch_trigger = 1'b1; measurement = m; step();
      latch_trigger = 1'b0; update_trigger = 1'b1; measurement = 16'hdead; step();
      update_trigger = 1'b0; predict_trigger = 1'b1; step();
      predict_trigger = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      checks++; if (position !== 16'd0) begin errors++; $display("FAIL reset_pos: got %0d want 0", position); end
      checks++; if (velocity !== 16'd0) begin errors++; $display("FAIL reset_vel: got %0d want 0", velocity); end
      checks++; if (residual !== 16'd0) begin errors++; $display("FAIL reset_res: got %0d want 0", residual); end
      checks++; if (estimate_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", estimate_valid); end
      checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", seq_error); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_priming();
      frame(16'd100);
      checks++; if (estimate_valid !== 1'b1) begin errors++; $display("FAIL prime_valid: got %b want 1", estimate_valid); end
      checks++; if (position !== 16'd100) begin errors++; $display("FAIL prime_pos: got %0d want 100", $signed(position)); end
      checks++; if (velocity !== 16'd0) begin errors++; $display("FAIL prime_vel: got %0d want 0", $signed(velocity)); end
      checks++; if (residual !== 16'd0) begin errors++; $display("FAIL prime_res: got %0d want 0", $signed(residual)); end
      step();
      checks++; if (estimate_valid !== 1'b0) begin errors++; $display("FAIL prime_valid_drop: got %b want 0", estimate_valid); end
   endtask

   task automatic test_tracking();
      frame(16'd116);
      checks++; if (residual !== 16'd16) begin errors++; $display("FAIL track_res: got %0d want 16", $signed(residual)); end
      checks++; if (velocity !== 16'd2) begin errors++; $display("FAIL track_vel: got %0d want 2", $signed(velocity)); end
      checks++; if (position !== 16'd110) begin errors++; $display("FAIL track_pos: got %0d want 110", $signed(position)); end
      checks++; if (estimate_valid !== 1'b1) begin errors++; $display("FAIL track_valid: got %b want 1", estimate_valid); end
      // Idle cycles hold everything
      step(); step(); step();
      checks++; if (position !== 16'd110 || velocity !== 16'd2 || estimate_valid !== 1'b0) begin
         errors++; $display("FAIL idle_hold: got pos=%0d vel=%0d valid=%b want 110 2 0", position, velocity, estimate_valid);
      end
   endtask

   task automatic test_ordering();
      do_reset();
      update_trigger = 1'b1; step(); update_trigger = 1'b0;
      checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL order_err: got %b want 1", seq_error); end
      checks++; if (position !== 16'd0 || estimate_valid !== 1'b0) begin
         errors++; $display("FAIL order_unchanged: got pos=%0d valid=%b want 0 0", position, estimate_valid);
      end
      frame(16'd100);
      checks++; if (position !== 16'd100) begin errors++; $display("FAIL order_recover_pos: got %0d want 100", $signed(position)); end
      checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL order_sticky: got %b want 1", seq_error); end
      // Latch and predict together: flagged, both ignored
      do_reset();
      latch_trigger = 1'b1; predict_trigger = 1'b1; measurement = 16'd900; step();
      latch_trigger = 1'b0; predict_trigger = 1'b0;
      checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL multi_err: got %b want 1", seq_error); end
      checks++; if (position !== 16'd0 || estimate_valid !== 1'b0) begin
         errors++; $display("FAIL multi_unchanged: got pos=%0d valid=%b want 0 0", position, estimate_valid);
      end
      // Still waiting for a latch: a full frame now primes normally
      frame(16'd50);
      checks++; if (position !== 16'd50) begin errors++; $display("FAIL multi_ignored: got %0d want 50", $signed(position)); end
      // Latch while awaiting update is ignored; measurement from the first latch is kept
      do_reset();
      latch_trigger = 1'b1; measurement = 16'd30; step();
      measurement = 16'd77; step();
      latch_trigger = 1'b0;
      checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL relatch_err: got %b want 1", seq_error); end
      update_trigger = 1'b1; step(); update_trigger = 1'b0;
      predict_trigger = 1'b1; step(); predict_trigger = 1'b0;
      checks++; if (position !== 16'd30 || estimate_valid !== 1'b1) begin
         errors++; $display("FAIL relatch_pos: got pos=%0d valid=%b want 30 1", position, estimate_valid);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      frame(16'h8000);
      checks++; if (position !== 16'h8000) begin errors++; $display("FAIL sat1_pos: got %0d want -32768", $signed(position)); end
      step();
      frame(16'h7fff);
      checks++; if (residual !== 16'd32767) begin errors++; $display("FAIL sat2_res: got %0d want 32767", $signed(residual)); end
      checks++; if (velocity !== 16'd8191) begin errors++; $display("FAIL sat2_vel: got %0d want 8191", $signed(velocity)); end
      checks++; if (position !== 16'd8190) begin errors++; $display("FAIL sat2_pos: got %0d want 8190", $signed(position)); end
      step();
      frame(16'h7fff);
      checks++; if (residual !== 16'd24577) begin errors++; $display("FAIL sat3_res: got %0d want 24577", $signed(residual)); end
      checks++; if (velocity !== 16'd11263) begin errors++; $display("FAIL sat3_vel: got %0d want 11263", $signed(velocity)); end
      checks++; if (position !== 16'd31741) begin errors++; $display("FAIL sat3_pos: got %0d want 31741", $signed(position)); end
      step();
      frame(16'h7fff);
      checks++; if (residual !== 16'd1026) begin errors++; $display("FAIL sat4_res: got %0d want 1026", $signed(residual)); end
      checks++; if (velocity !== 16'd11391) begin errors++; $display("FAIL sat4_vel: got %0d want 11391", $signed(velocity)); end
      checks++; if (position !== 16'd32767) begin errors++; $display("FAIL sat4_pos: got %0d want 32767", $signed(position)); end
      checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL sat_err: got %b want 0", seq_error); end
   endtask

   task automatic test_reset_midframe();
      step();
      latch_trigger = 1'b1; measurement = 16'd500; step(); latch_trigger = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (position !== 16'd0 || velocity !== 16'd0 || residual !== 16'd0) begin
         errors++; $display("FAIL async_reset_data: got pos=%0d vel=%0d res=%0d want 0 0 0", position, velocity, residual);
      end
      checks++; if (estimate_valid !== 1'b0 || seq_error !== 1'b0) begin
         errors++; $display("FAIL async_reset_ctrl: got valid=%b err=%b want 0 0", estimate_valid, seq_error);
      end
      #1 reset = 1'b0;
      step();
      frame(16'd50);
      checks++; if (position !== 16'd50) begin errors++; $display("FAIL midreset_pos: got %0d want 50", $signed(position)); end
      checks++; if (velocity !== 16'd0 || residual !== 16'd0) begin
         errors++; $display("FAIL midreset_state: got vel=%0d res=%0d want 0 0", velocity, residual);
      end
      checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b want 0", seq_error); end
   endtask

   initial begin
      test_reset();
      test_priming();
      test_tracking();
      test_ordering();
      test_saturation();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
